// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the dmemory32 word port: sub-word stores via read-modify-write.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word requests are trapped instead of aligned.
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_misalign,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateT;

  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

  stateT       state;
  logic [1:0]  latCnt;
  logic        writeReg;
  logic [1:0]  sizeReg;
  logic        signedReg;
  logic [1:0]  offsetReg;
  logic [15:0] wdataReg;

  logic        misalignIn;
  logic [1:0]  offsetIn;
  logic [3:0]  laneSel;
  logic [31:0] mergeWord;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;

  // Lane offset is forced to natural alignment; with trapping on, only aligned requests reach it.
  always_comb begin
    misalignIn = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalignIn = (req_size == 2'b01 && req_addr[0]) ||
                 (req_size[1] && req_addr[1:0] != 2'b00);
`endif
    offsetIn = 2'b00;
    case (req_size)
      2'b00:   offsetIn = req_addr[1:0];
      2'b01:   offsetIn = {req_addr[1], 1'b0};
      default: offsetIn = 2'b00;
    endcase
  end

  always_comb begin
    laneSel = 4'b1111;
    case (sizeReg)
      2'b00:   laneSel = 4'b0001 << offsetReg;
      2'b01:   laneSel = offsetReg[1] ? 4'b1100 : 4'b0011;
      default: laneSel = 4'b1111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      assign mergeWord[8*gi +: 8] = !laneSel[gi]       ? mem_rdata[8*gi +: 8] :
                                    (sizeReg == 2'b00) ? wdataReg[7:0]        :
                                                         wdataReg[8*(gi%2) +: 8];
    end
  endgenerate

  always_comb begin
    byteLane = mem_rdata[{offsetReg, 3'b000} +: 8];
    halfLane = offsetReg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (sizeReg)
      2'b00:   loadData = {{24{signedReg & byteLane[7]}}, byteLane};
      2'b01:   loadData = {{16{signedReg & halfLane[15]}}, halfLane};
      default: loadData = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      latCnt       <= 2'd0;
      writeReg     <= 1'b0;
      sizeReg      <= 2'b00;
      signedReg    <= 1'b0;
      offsetReg    <= 2'b00;
      wdataReg     <= 16'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_misalign <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_write    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            writeReg     <= req_write;
            sizeReg      <= req_size;
            signedReg    <= req_signed;
            offsetReg    <= offsetIn;
            wdataReg     <= req_wdata[15:0];
            latCnt       <= 2'd0;
            req_ready    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_misalign <= 1'b0;
            mem_addr     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (misalignIn) begin
              rsp_misalign <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end else if (req_write && req_size[1]) begin
              mem_wdata <= req_wdata;
              mem_write <= 1'b1;
              state     <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (latCnt == LAST_CNT) begin
            if (writeReg) begin
              mem_wdata <= mergeWord;
              mem_write <= 1'b1;
              state     <= WRITE;
            end else begin
              rsp_rdata <= loadData;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else begin
            latCnt <= latCnt + 2'd1;
          end
        end
        WRITE: begin
          mem_write <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: two instances (READ_LATENCY 1 and 2) against a word memory model.
// Expectations follow the DMEM_MISALIGN_TRAP_EN setting of the build.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        reqValid   [2];
  logic        reqReady   [2];
  logic        reqWrite   [2];
  logic [1:0]  reqSize    [2];
  logic        reqSigned  [2];
  logic [31:0] reqAddr    [2];
  logic [31:0] reqWdata   [2];
  logic        rspValid   [2];
  logic        rspReady   [2];
  logic [31:0] rspRdata   [2];
  logic        rspMisalign[2];
  logic [31:0] memAddr    [2];
  logic [31:0] memWdata   [2];
  logic        memWrite   [2];
  logic [31:0] memRdata   [2];

  bit [31:0] mem [2][16];
  int        wrCnt [2];
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gDut
      dmem_access_ctrl #(.ADDR_WIDTH(32), .READ_LATENCY(gi + 1)) dut (
        .clock       (clk),
        .reset       (rst[gi]),
        .req_valid   (reqValid[gi]),
        .req_ready   (reqReady[gi]),
        .req_write   (reqWrite[gi]),
        .req_size    (reqSize[gi]),
        .req_signed  (reqSigned[gi]),
        .req_addr    (reqAddr[gi]),
        .req_wdata   (reqWdata[gi]),
        .rsp_valid   (rspValid[gi]),
        .rsp_ready   (rspReady[gi]),
        .rsp_rdata   (rspRdata[gi]),
        .rsp_misalign(rspMisalign[gi]),
        .mem_addr    (memAddr[gi]),
        .mem_wdata   (memWdata[gi]),
        .mem_write   (memWrite[gi]),
        .mem_rdata   (memRdata[gi])
      );
      assign memRdata[gi] = mem[gi][memAddr[gi][5:2]];
    end
  endgenerate

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (memWrite[d]) begin
        mem[d][memAddr[d][5:2]] <= memWdata[d];
        wrCnt[d] <= wrCnt[d] + 1;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expMis;
    logic [31:0] expMem;
    int          latBase;
    logic        useRl;
    int          expWr;
  } vecT;

  localparam int NVEC = 19;
  vecT vecs [NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic runVec(input int d, input int i, input vecT v);
    int lat;
    int w0;
    int expLat;
    expLat = v.latBase + (v.useRl ? d + 1 : 0);
    @(negedge clk);
    check("idle req_ready", reqReady[d], 1);
    reqValid[d] = 1; reqWrite[d] = v.wr; reqSize[d] = v.size; reqSigned[d] = v.sgn;
    reqAddr[d] = v.addr; reqWdata[d] = v.wdata; rspReady[d] = 0;
    w0 = wrCnt[d];
    @(posedge clk); #1;
    reqValid[d] = 0; reqWrite[d] = 1'($urandom); reqAddr[d] = $urandom; reqWdata[d] = $urandom;
    lat = 0;
    while (!rspValid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, expLat);
    check("rsp_rdata", rspRdata[d], v.expRdata);
    check("rsp_misalign", rspMisalign[d], v.expMis);
    if (!v.expMis) check("mem_addr", memAddr[d], {v.addr[31:2], 2'b00});
    check("write pulses", wrCnt[d] - w0, v.expWr);
    rspReady[d] = 1;
    @(posedge clk); #1;
    rspReady[d] = 0;
    check("ready after rsp", reqReady[d], 1);
    check("rsp_valid cleared", rspValid[d], 0);
    check("memory word", mem[d][v.addr[5:2]], v.expMem);
    $display("txn dut=%0d vec=%0d wr=%0b size=%0d addr=0x%02h rdata=0x%08h mis=%0b lat=%0d mem=0x%08h",
             d, i, v.wr, v.size, v.addr[7:0], rspRdata[d], rspMisalign[d], lat, mem[d][v.addr[5:2]]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] word10;
    int          lat;
    int          w0;
    bit          seen;

`ifdef DMEM_MISALIGN_TRAP_EN
    word10 = 32'h1234abf5;
`else
    word10 = 32'h5678abf5;
`endif

    //           wr  size   sgn  addr   wdata         rdata         mis   mem           lb rl wr
    vecs[0]  = '{1, 2'b10, 0, 32'h10, 32'ha0000000, 32'h0,        1'b0, 32'ha0000000, 1, 0, 1};
    vecs[1]  = '{1, 2'b00, 0, 32'h10, 32'h000000f5, 32'h0,        1'b0, 32'ha00000f5, 1, 1, 1};
    vecs[2]  = '{1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0,        1'b0, 32'h123400f5, 1, 1, 1};
    vecs[3]  = '{0, 2'b00, 1, 32'h10, 32'h0,        32'hfffffff5, 1'b0, 32'h123400f5, 0, 1, 0};
    vecs[4]  = '{0, 2'b00, 0, 32'h10, 32'h0,        32'h000000f5, 1'b0, 32'h123400f5, 0, 1, 0};
    vecs[5]  = '{0, 2'b10, 0, 32'h10, 32'h0,        32'h123400f5, 1'b0, 32'h123400f5, 0, 1, 0};
    vecs[6]  = '{0, 2'b01, 1, 32'h12, 32'h0,        32'h00001234, 1'b0, 32'h123400f5, 0, 1, 0};
    vecs[7]  = '{1, 2'b01, 0, 32'h16, 32'h00008001, 32'h0,        1'b0, 32'h80010000, 1, 1, 1};
    vecs[8]  = '{0, 2'b01, 1, 32'h16, 32'h0,        32'hffff8001, 1'b0, 32'h80010000, 0, 1, 0};
    vecs[9]  = '{0, 2'b01, 0, 32'h16, 32'h0,        32'h00008001, 1'b0, 32'h80010000, 0, 1, 0};
    vecs[10] = '{0, 2'b00, 1, 32'h17, 32'h0,        32'hffffff80, 1'b0, 32'h80010000, 0, 1, 0};
    vecs[11] = '{0, 2'b00, 0, 32'h16, 32'h0,        32'h00000001, 1'b0, 32'h80010000, 0, 1, 0};
    vecs[12] = '{1, 2'b00, 0, 32'h11, 32'hffffffab, 32'h0,        1'b0, 32'h1234abf5, 1, 1, 1};
    vecs[13] = '{0, 2'b10, 0, 32'h10, 32'h0,        32'h1234abf5, 1'b0, 32'h1234abf5, 0, 1, 0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[14] = '{0, 2'b10, 0, 32'h11, 32'h0,        32'h0,        1'b1, 32'h1234abf5, 0, 0, 0};
    vecs[15] = '{1, 2'b01, 0, 32'h13, 32'h00005678, 32'h0,        1'b1, 32'h1234abf5, 0, 0, 0};
`else
    vecs[14] = '{0, 2'b10, 0, 32'h11, 32'h0,        32'h1234abf5, 1'b0, 32'h1234abf5, 0, 1, 0};
    vecs[15] = '{1, 2'b01, 0, 32'h13, 32'h00005678, 32'h0,        1'b0, 32'h5678abf5, 1, 1, 1};
`endif
    vecs[16] = '{1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0,        1'b0, 32'h11223344, 1, 0, 1};
    vecs[17] = '{0, 2'b01, 1, 32'h22, 32'h0,        32'h00001122, 1'b0, 32'h11223344, 0, 1, 0};
    vecs[18] = '{0, 2'b11, 1, 32'h10, 32'h0,        word10,       1'b0, word10,       0, 1, 0};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; reqValid[d] = 0; reqWrite[d] = 0; reqSize[d] = 0; reqSigned[d] = 0;
      reqAddr[d] = 0; reqWdata[d] = 0; rspReady[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset req_ready", reqReady[d], 1);
      check("reset rsp_valid", rspValid[d], 0);
      check("reset rsp_rdata", rspRdata[d], 0);
      check("reset rsp_misalign", rspMisalign[d], 0);
      check("reset mem_addr", memAddr[d], 0);
      check("reset mem_wdata", memWdata[d], 0);
      check("reset mem_write", memWrite[d], 0);
    end
    @(negedge clk);
    rst[0] = 0; rst[1] = 0;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NVEC; i++)
        runVec(d, i, vecs[i]);

    // Response held back: outputs frozen, new requests ignored until the handshake.
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      reqValid[d] = 1; reqWrite[d] = 0; reqSize[d] = 2'b10; reqSigned[d] = 0; reqAddr[d] = 32'h10;
      rspReady[d] = 0;
      w0 = wrCnt[d];
      @(posedge clk); #1;
      reqWrite[d] = 1; reqAddr[d] = 32'h24; reqWdata[d] = 32'hdeadbeef;
      lat = 0;
      while (!rspValid[d] && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("hold first rsp", rspValid[d], 1);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        check("hold rsp_valid", rspValid[d], 1);
        check("hold rsp_rdata", rspRdata[d], word10);
        check("hold req_ready", reqReady[d], 0);
      end
      rspReady[d] = 1;
      @(posedge clk); #1;
      reqValid[d] = 0; rspReady[d] = 0;
      check("hold release ready", reqReady[d], 1);
      repeat (3) @(posedge clk);
      #1;
      check("hold no write", wrCnt[d] - w0, 0);
      check("hold mem 0x24", mem[d][9], 0);
      $display("txn dut=%0d backpressure rdata=0x%08h writes=%0d", d, rspRdata[d], wrCnt[d] - w0);
    end

    // Reset while the merged byte is being written: the store must be abandoned.
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      reqValid[d] = 1; reqWrite[d] = 1; reqSize[d] = 2'b00; reqAddr[d] = 32'h20; reqWdata[d] = 32'hee;
      @(posedge clk); #1;
      reqValid[d] = 0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (memWrite[d]) seen = 1;
        else begin
          @(posedge clk); #1;
        end
      end
      check("reset test write seen", seen, 1);
      rst[d] = 1;
      #1;
      check("reset drops mem_write", memWrite[d], 0);
      check("reset drops rsp_valid", rspValid[d], 0);
      @(posedge clk);
      @(negedge clk);
      rst[d] = 0;
      @(posedge clk); #1;
      check("reset release ready", reqReady[d], 1);
      check("reset word intact", mem[d][8], 32'h11223344);
      check("reset no response", rspValid[d], 0);
      $display("txn dut=%0d reset-in-write mem=0x%08h ready=%0b", d, mem[d][8], reqReady[d]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
